// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter/mux: one ready/valid sink shared by N masters, grant locked per burst.
// Latency: grant one edge after request is sampled; data path is combinational (no beat latency).
// Backpressure: s_ready passes only to the granted master; the others see m_ready=0. Optional BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    m_req,
    input  logic [N-1:0]    m_valid,
    input  logic [N-1:0]    m_last,
    input  logic [N*DW-1:0] m_data,
    output logic [N-1:0]    m_ready,
    output logic            s_valid,
    output logic [DW-1:0]   s_data,
    output logic            s_last,
    input  logic            s_ready,
    output logic [N-1:0]    gnt,
    output logic            busy,
    output logic            timeout_err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    generate
        if (N < 2 || N > 8 || TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_param
            $error("bus_rr_arbiter: parameter out of range");
        end
    endgenerate

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] nxt_ptr;
    logic [PW:0]   scan_sum;
    logic          beat_hs;
    logic          last_hs;
    logic          expire;

    // Scan from the highest offset down so the offset nearest ptr is the one left standing.
    always_comb begin
        pick_idx = ptr;
        scan_sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_sum = {1'b0, ptr} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(N)) begin
                scan_sum = scan_sum - (PW+1)'(N);
            end
            if (m_req[scan_sum[PW-1:0]]) begin
                pick_idx = scan_sum[PW-1:0];
            end
        end
    end

    assign nxt_ptr = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);

    always_comb begin
        s_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                s_data = s_data | m_data[i*DW +: DW];
            end
        end
    end

    assign s_valid = |(m_valid & gnt);
    assign s_last  = |(m_last & gnt);
    assign m_ready = gnt & {N{s_ready}};
    assign beat_hs = s_valid & s_ready;
    assign last_hs = beat_hs & s_last;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] stall_cnt;

    // Any accepted beat counts as progress, not just the last one.
    assign expire = (state == GRANT) && (stall_cnt == STALL_LIMIT) && !beat_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE || beat_hs) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            ptr         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|m_req) begin
                        state   <= GRANT;
                        gnt     <= N'(1) << pick_idx;
                        gnt_idx <= pick_idx;
                        busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (last_hs || expire) begin
                        state       <= IDLE;
                        gnt         <= '0;
                        ptr         <= nxt_ptr;
                        busy        <= 1'b0;
                        timeout_err <= expire;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: reset, rotation, lock, backpressure, fairness, reset mid-burst, timeout.
// Timeout expectations follow BUS_ARB_TIMEOUT_EN as defined for the build.
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_valid;
    logic [N-1:0]    m_last;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic            s_last;
    logic            s_ready;
    logic [N-1:0]    gnt;
    logic            busy;
    logic            timeout_err;

    int n_chk    = 0;
    int n_pass   = 0;
    int cur_beat = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter #(.N(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req       (m_req),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .gnt         (gnt),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] vld;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] exp_gnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dat_of(input int m, input int b);
        return 32'hA000_0000 + (32'(m) << 16) + 32'(b);
    endfunction

    function automatic void add_vec(input logic [3:0] req, input logic [3:0] vld,
                                    input logic [3:0] last, input logic rdy,
                                    input logic [3:0] exp_gnt);
        vec_t v;
        v.req     = req;
        v.vld     = vld;
        v.last    = last;
        v.rdy     = rdy;
        v.exp_gnt = exp_gnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] req, input logic [3:0] vld,
                         input logic [3:0] last, input logic rdy, input int beat);
        m_req    = req;
        m_valid  = vld;
        m_last   = last;
        s_ready  = rdy;
        cur_beat = beat;
        for (int i = 0; i < N; i++) begin
            m_data[i*DW +: DW] = dat_of(i, beat);
        end
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] vld,
                         input logic [3:0] last, input logic rdy, input int beat);
        @(negedge clk);
        apply(req, vld, last, rdy, beat);
    endtask

    // Expected outputs derive from the expected grant and the stimulus the bench is driving.
    task automatic check_outs(input string tag, input logic [3:0] eg, input logic exp_te);
        logic [31:0] ed;
        ed = '0;
        for (int i = 0; i < N; i++) begin
            if (eg[i]) ed = dat_of(i, cur_beat);
        end
        chk({tag, ".gnt"},         32'(gnt),         32'(eg));
        chk({tag, ".busy"},        32'(busy),        32'(|eg));
        chk({tag, ".m_ready"},     32'(m_ready),     32'(eg & {4{s_ready}}));
        chk({tag, ".s_valid"},     32'(s_valid),     32'(|(eg & m_valid)));
        chk({tag, ".s_last"},      32'(s_last),      32'(|(eg & m_last)));
        chk({tag, ".s_data"},      32'(s_data),      ed);
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(exp_te));
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] eg;
        logic       ete;
        int         rdy_seq [5] = '{1, 0, 1, 0, 1};
        int         beat_seq[5] = '{0, 1, 1, 2, 2};

        // Rotation from ptr=0: two-beat bursts with a dead cycle between each.
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            add_vec(4'hF, 4'hF, 4'h0, 1'b1, g);
            add_vec(4'hF, 4'hF, 4'hF, 1'b1, g);
            add_vec((k == 4) ? 4'b1001 : 4'hF, 4'hF, 4'hF, 1'b1, 4'b0000);
        end
        // Fairness with ptr=1 and requests on m0/m3, single-beat bursts.
        add_vec(4'b1001, 4'b1000, 4'b1000, 1'b1, 4'b1000);
        add_vec(4'b1001, 4'hF,    4'hF,    1'b1, 4'b0000);
        add_vec(4'b1001, 4'b0001, 4'b0001, 1'b1, 4'b0001);
        add_vec(4'b0000, 4'hF,    4'hF,    1'b1, 4'b0000);
        add_vec(4'b0000, 4'h0,    4'h0,    1'b1, 4'b0000);

        rst_n   = 1'b1;
        m_req   = 4'hF;
        m_valid = 4'hF;
        m_last  = 4'h0;
        s_ready = 1'b1;
        m_data  = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 4'b0000, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(4'hF, 4'hF, 4'h0, 1'b1, 0);
        check_outs("reset_exit", 4'b0000, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].vld, vecs[i].last, vecs[i].rdy, 0);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_gnt, 1'b0);
        end

        // Lock: m1 drops its request after beat 1 and stalls five cycles.
        drive(4'b0010, 4'b0000, 4'b0000, 1'b1, 0);
        check_outs("lock_idle", 4'b0000, 1'b0);
        drive(4'b0010, 4'b0010, 4'b0000, 1'b1, 0);
        check_outs("lock_beat1", 4'b0010, 1'b0);
        drive(4'b0010, 4'b0000, 4'b0000, 1'b1, 0);
        check_outs("lock_novalid", 4'b0010, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(4'b0000, 4'b0010, 4'b0010, 1'b0, 0);
            check_outs($sformatf("lock_stall%0d", c), 4'b0010, 1'b0);
        end
        drive(4'b0000, 4'b0010, 4'b0010, 1'b1, 0);
        check_outs("lock_last", 4'b0010, 1'b0);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 0);
        check_outs("lock_release", 4'b0000, 1'b0);

        // Backpressure: 3-beat burst from m2, everyone else valid and requesting.
        drive(4'hF, 4'hF, 4'h0, 1'b1, 0);
        check_outs("bp_idle", 4'b0000, 1'b0);
        for (int s = 0; s < 5; s++) begin
            drive(4'hF, 4'hF, (beat_seq[s] == 2) ? 4'hF : 4'h0, rdy_seq[s][0], beat_seq[s]);
            check_outs($sformatf("bp_step%0d", s), 4'b0100, 1'b0);
        end
        drive(4'hF, 4'h0, 4'h0, 1'b1, 0);
        check_outs("bp_dead", 4'b0000, 1'b0);
        drive(4'hF, 4'h0, 4'h0, 1'b1, 0);
        check_outs("m3_grant", 4'b1000, 1'b0);

        // Asynchronous reset mid-burst, away from any clock edge.
        #2;
        m_valid = 4'hF;
        rst_n   = 1'b0;
        #1;
        chk("midrst.gnt",     32'(gnt),     32'h0);
        chk("midrst.busy",    32'(busy),    32'h0);
        chk("midrst.s_valid", 32'(s_valid), 32'h0);
        chk("midrst.m_ready", 32'(m_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1010, 4'b0000, 4'b0000, 1'b1, 0);
        check_outs("midrst_exit", 4'b0000, 1'b0);
        drive(4'b1010, 4'b0010, 4'b0010, 1'b1, 0);
        check_outs("midrst_ptr0", 4'b0010, 1'b0);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 0);
        check_outs("midrst_done", 4'b0000, 1'b0);

        // Stalled grant: m0 granted and never presents a beat.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b0011, 4'b0000, 4'b0000, 1'b1, 0);
        check_outs("to_idle", 4'b0000, 1'b0);
        for (int c = 0; c < 20; c++) begin
            drive(4'b0011, 4'b0000, 4'b0000, 1'b1, 0);
`ifdef BUS_ARB_TIMEOUT_EN
            eg  = (c < 16) ? 4'b0001 : ((c == 16) ? 4'b0000 : 4'b0010);
            ete = (c == 16);
`else
            eg  = 4'b0001;
            ete = 1'b0;
`endif
            check_outs($sformatf("to_c%0d", c), eg, ete);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
